// File: rtl/unidade_controle_mc.sv
// Multicycle control unit for the 8-bit MIPS-subset datapath.
// State is registered; datapath controls are a Moore decode of the state (PCEn also uses flagZ).
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+1
// DECODE | compute branch target, dispatch on opcode/funct
// MEMADR | ULA computes regA + imm for lw/sw
// MEMRD  | read data memory at ULAOut
// MEMWB  | write MDR into rt
// MEMWR  | write regB into data memory at ULAOut
// EXEC   | R-type operation on regA/regB
// ALUWB  | write ULAOut into rd
// BRANCH | beq compare, PC <= target when zero
// ADDIEX | regA + imm
// ADDIWB | write ULAOut into rt
// JUMP   | PC <= jump target
// HALT   | stopped on illegal opcode until reset
module unidade_controle_mc #(
    parameter int STATE_W  = 4,
    parameter bit ILL_HALT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               flagZ,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic [2:0]         ULAControl,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     r_state;
    logic       w_funct_ok;
    logic [2:0] w_funct_ula;
    logic       w_is_r;
    logic       w_is_mem;
    logic       w_pcwrite;
    logic       w_branch;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_ula = 3'b010;
        case (funct)
            6'b100000: w_funct_ula = 3'b010;
            6'b100010: w_funct_ula = 3'b110;
            6'b100100: w_funct_ula = 3'b000;
            6'b100101: w_funct_ula = 3'b001;
            6'b100111: w_funct_ula = 3'b011;
            6'b101010: w_funct_ula = 3'b111;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    assign w_is_r   = (opcode == OP_R) && w_funct_ok;
    assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_is_mem)                r_state <= S_MEMADR;
                    else if (w_is_r)             r_state <= S_EXEC;
                    else if (opcode == OP_BEQ)   r_state <= S_BRANCH;
                    else if (opcode == OP_ADDI)  r_state <= S_ADDIEX;
                    else if (opcode == OP_J)     r_state <= S_JUMP;
                    else if (ILL_HALT)           r_state <= S_HALT;
                    else                         r_state <= S_FETCH;
                end
                S_MEMADR: r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXEC:   r_state <= S_ALUWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ULAControl = 3'b000;
        illegal    = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ULAControl = 3'b010;
                w_pcwrite  = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ULAControl = 3'b010;
                illegal    = !(w_is_mem || w_is_r || opcode == OP_BEQ
                               || opcode == OP_ADDI || opcode == OP_J);
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ULAControl = 3'b010;
            end
            S_MEMRD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ULAControl = w_funct_ula;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ULAControl = 3'b110;
                PCSrc      = 2'b01;
                w_branch   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must suppress every write strobe even though the state already reads FETCH.
        if (!rst_n) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            illegal    = 1'b0;
            w_pcwrite  = 1'b0;
            w_branch   = 1'b0;
            ULAControl = 3'b010;
        end
    end

    assign PCEn    = w_pcwrite | (w_branch & flagZ);
    assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed bench for unidade_controle_mc; two instances cover both illegal-opcode policies.
module tb_unidade_controle_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       flagZ = 1'b0;

    logic       a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemtoReg, a_RegWrite, a_ALUSrcA;
    logic [1:0] a_ALUSrcB, a_PCSrc;
    logic       a_PCEn, a_illegal;
    logic [2:0] a_ULAControl;
    logic [3:0] a_state;

    logic       b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemtoReg, b_RegWrite, b_ALUSrcA;
    logic [1:0] b_ALUSrcB, b_PCSrc;
    logic       b_PCEn, b_illegal;
    logic [2:0] b_ULAControl;
    logic [3:0] b_state;

    unidade_controle_mc #(.STATE_W(4), .ILL_HALT(1'b0)) u_skip (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .flagZ(flagZ),
        .IorD(a_IorD), .MemWrite(a_MemWrite), .IRWrite(a_IRWrite), .RegDst(a_RegDst),
        .MemtoReg(a_MemtoReg), .RegWrite(a_RegWrite), .ALUSrcA(a_ALUSrcA),
        .ALUSrcB(a_ALUSrcB), .PCSrc(a_PCSrc), .PCEn(a_PCEn), .ULAControl(a_ULAControl),
        .illegal(a_illegal), .state_o(a_state)
    );

    unidade_controle_mc #(.STATE_W(4), .ILL_HALT(1'b1)) u_halt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .flagZ(flagZ),
        .IorD(b_IorD), .MemWrite(b_MemWrite), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA),
        .ALUSrcB(b_ALUSrcB), .PCSrc(b_PCSrc), .PCEn(b_PCEn), .ULAControl(b_ULAControl),
        .illegal(b_illegal), .state_o(b_state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [5:0] fn_tab [6];
    logic [2:0] ul_tab [6];

    initial begin
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        ul_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b011,    3'b111};

        // reset held
        repeat (3) step();
        chk("rst_state", a_state, 4'd0);
        chk("rst_irwrite", a_IRWrite, 1'b0);
        chk("rst_pcen", a_PCEn, 1'b0);
        chk("rst_ula", a_ULAControl, 3'b010);
        chk("rst_illegal", a_illegal, 1'b0);

        rst_n = 1'b1;
        #1;
        chk("fetch_irwrite", a_IRWrite, 1'b1);
        chk("fetch_pcen", a_PCEn, 1'b1);
        chk("fetch_srcb", a_ALUSrcB, 2'b01);

        // R-type group
        opcode = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = fn_tab[i];
            step();
            chk("r_decode", a_state, 4'd1);
            chk("r_decode_srcb", a_ALUSrcB, 2'b11);
            chk("r_decode_ill", a_illegal, 1'b0);
            step();
            chk("r_exec", a_state, 4'd6);
            chk("r_exec_ula", a_ULAControl, ul_tab[i]);
            chk("r_exec_regwrite", a_RegWrite, 1'b0);
            chk("r_exec_srca", a_ALUSrcA, 1'b1);
            step();
            chk("r_aluwb", a_state, 4'd7);
            chk("r_aluwb_regwrite", a_RegWrite, 1'b1);
            chk("r_aluwb_regdst", a_RegDst, 1'b1);
            step();
            chk("r_fetch", a_state, 4'd0);
            chk("r_fetch_regwrite", a_RegWrite, 1'b0);
        end

        // lw
        opcode = 6'b100011;
        step(); chk("lw_decode", a_state, 4'd1);
        step(); chk("lw_memadr", a_state, 4'd2);
        chk("lw_memadr_srcb", a_ALUSrcB, 2'b10);
        step(); chk("lw_memrd", a_state, 4'd3);
        chk("lw_memrd_iord", a_IorD, 1'b1);
        step(); chk("lw_memwb", a_state, 4'd4);
        chk("lw_memwb_memtoreg", a_MemtoReg, 1'b1);
        chk("lw_memwb_regwrite", a_RegWrite, 1'b1);
        chk("lw_memwb_regdst", a_RegDst, 1'b0);
        step(); chk("lw_fetch", a_state, 4'd0);

        // beq taken then not taken
        opcode = 6'b000100;
        flagZ  = 1'b1;
        step(); chk("beq_decode", a_state, 4'd1);
        chk("beq_decode_pcen", a_PCEn, 1'b0);
        step(); chk("beq_branch", a_state, 4'd8);
        chk("beq_z1_pcen", a_PCEn, 1'b1);
        chk("beq_pcsrc", a_PCSrc, 2'b01);
        chk("beq_ula", a_ULAControl, 3'b110);
        flagZ = 1'b0;
        #1;
        chk("beq_z0_pcen", a_PCEn, 1'b0);
        step(); chk("beq_fetch", a_state, 4'd0);

        // j
        opcode = 6'b000010;
        step(); chk("j_decode", a_state, 4'd1);
        step(); chk("j_jump", a_state, 4'd11);
        chk("j_pcsrc", a_PCSrc, 2'b10);
        chk("j_pcen", a_PCEn, 1'b1);
        step(); chk("j_fetch", a_state, 4'd0);

        // addi
        opcode = 6'b001000;
        step(); chk("addi_decode", a_state, 4'd1);
        step(); chk("addi_ex", a_state, 4'd9);
        chk("addi_ex_srcb", a_ALUSrcB, 2'b10);
        step(); chk("addi_wb", a_state, 4'd10);
        chk("addi_wb_regwrite", a_RegWrite, 1'b1);
        chk("addi_wb_regdst", a_RegDst, 1'b0);
        step(); chk("addi_fetch", a_state, 4'd0);

        // sw aborted by reset while in MEMWR
        opcode = 6'b101011;
        step(); chk("sw_decode", a_state, 4'd1);
        step(); chk("sw_memadr", a_state, 4'd2);
        step(); chk("sw_memwr", a_state, 4'd5);
        chk("sw_memwrite", a_MemWrite, 1'b1);
        chk("sw_iord", a_IorD, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_state", a_state, 4'd0);
        chk("mrst_memwrite", a_MemWrite, 1'b0);
        chk("mrst_pcen", a_PCEn, 1'b0);
        repeat (3) step();
        chk("mrst_hold_state", a_state, 4'd0);
        chk("mrst_hold_irwrite", a_IRWrite, 1'b0);
        opcode = 6'b111111;
        rst_n  = 1'b1;
        #1;
        chk("mrst_rel_irwrite", a_IRWrite, 1'b1);

        // illegal opcode on both policies
        step();
        chk("ill_decode", a_state, 4'd1);
        chk("ill_pulse_skip", a_illegal, 1'b1);
        chk("ill_pulse_halt", b_illegal, 1'b1);
        step();
        chk("ill_skip_fetch", a_state, 4'd0);
        chk("ill_skip_noill", a_illegal, 1'b0);
        chk("ill_halt_state", b_state, 4'd12);
        chk("ill_halt_irwrite", b_IRWrite, 1'b0);
        chk("ill_halt_pcen", b_PCEn, 1'b0);
        step();
        chk("ill_skip_decode2", a_state, 4'd1);
        chk("ill_halt_state2", b_state, 4'd12);
        opcode = 6'b000000;
        funct  = 6'b000001;
        #1;
        chk("ill_funct_pulse", a_illegal, 1'b1);
        step();
        chk("ill_funct_fetch", a_state, 4'd0);
        step();
        chk("ill_halt_state3", b_state, 4'd12);
        chk("ill_halt_illegal", b_illegal, 1'b0);

        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", b_state, 4'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("halt_rel_decode", b_state, 4'd1);
        chk("halt_rel_illegal", b_illegal, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
